// File: rtl/truco_pkg.sv
// Shared types and constants for the truco hand controller slice.
package truco_pkg;

    // A hand is at most three vazas long.
    localparam int MAX_VAZAS = 3;

    // Controller state encoding, kept as plain constants for legacy tools.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_COLLECT = 2'd1;
    localparam state_t ST_RESOLVE = 2'd2;
    localparam state_t ST_DONE    = 2'd3;

    // Outcome of one vaza: won=0 means it was tied (team is then 0).
    typedef struct packed {
        logic won;
        logic team;
    } vaza_result_t;

endpackage

// File: rtl/truco_vaza_cmp.sv
// Running best-card tracker for a single vaza.
// Keeps the highest rank seen so far, who played it, and whether the
// opposing team has matched it.
module truco_vaza_cmp #(
    parameter int NUM_PLAYERS = 2,
    parameter int RANK_W      = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           load,
    input  logic                           first,
    input  logic [RANK_W-1:0]              card_rank,
    input  logic [$clog2(NUM_PLAYERS)-1:0] card_player,
    output logic [RANK_W-1:0]              best_rank,
    output logic [$clog2(NUM_PLAYERS)-1:0] best_player,
    output logic                           tie_flag
);

    // Update the running best; the first card of a vaza always takes the lead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_rank   <= '0;
            best_player <= '0;
            tie_flag    <= 1'b0;
        end else if (clear) begin
            best_rank   <= '0;
            best_player <= '0;
            tie_flag    <= 1'b0;
        end else if (load) begin
            if (first || (card_rank > best_rank)) begin
                best_rank   <= card_rank;
                best_player <= card_player;
                tie_flag    <= 1'b0;
            end else if ((card_rank == best_rank) && (card_player[0] != best_player[0])) begin
                tie_flag    <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/truco_hand_ctrl.sv
// Best-of-three truco hand controller.
// Collects one card per player per vaza over ready/valid, resolves each
// vaza and applies the hand rules to report the hand winner.
module truco_hand_ctrl
    import truco_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int RANK_W      = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [$clog2(NUM_PLAYERS)-1:0] first_player,
    input  logic                           card_valid,
    output logic                           card_ready,
    input  logic [RANK_W-1:0]              card_rank,
    output logic [$clog2(NUM_PLAYERS)-1:0] cur_player,
    output logic [1:0]                     vaza_idx,
    output logic                           vaza_done,
    output logic                           vaza_tie,
    output logic                           vaza_team,
    output logic                           hand_done,
    output logic                           hand_tie,
    output logic                           hand_team
);

    localparam int PW = $clog2(NUM_PLAYERS);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] LAST_CARD   = CW'(NUM_PLAYERS - 1);
    localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);

    state_t                          state;
    logic   [PW-1:0]                 leader;
    logic   [CW-1:0]                 card_cnt;
    vaza_result_t [MAX_VAZAS-1:0]    hist;
    vaza_result_t [MAX_VAZAS-1:0]    hist_next;
    vaza_result_t                    cur_result;
    logic   [2:0]                    decision;

    logic                            idle_like;
    logic                            begin_hand;
    logic                            transfer;
    logic                            cmp_clear;
    logic   [RANK_W-1:0]             best_rank;
    logic   [PW-1:0]                 best_player;
    logic                            tie_flag;
    logic   [PW-1:0]                 next_player;

    // Hand rules over the first n vazas; returns {decided, tie, team}.
    function automatic logic [2:0] decide(input vaza_result_t [MAX_VAZAS-1:0] h,
                                          input logic [1:0] n);
        logic [1:0] wins0;
        logic [1:0] wins1;
        logic       dec;
        logic       tie;
        logic       team;
        wins0 = '0;
        wins1 = '0;
        dec   = 1'b0;
        tie   = 1'b0;
        team  = 1'b0;
        for (int i = 0; i < MAX_VAZAS; i++) begin
            if ((i < int'(n)) && h[i].won) begin
                if (h[i].team) wins1 = wins1 + 2'd1;
                else           wins0 = wins0 + 2'd1;
            end
        end
        if (wins0 >= 2'd2) begin
            dec = 1'b1;
        end else if (wins1 >= 2'd2) begin
            dec  = 1'b1;
            team = 1'b1;
        end else if ((n >= 2'd2) && (h[0].won != h[1].won)) begin
            // one of the first two vazas tied: the won one decides
            dec  = 1'b1;
            team = h[0].won ? h[0].team : h[1].team;
        end else if (n == 2'd3) begin
            // either split 1-1 or two ties so far
            dec = 1'b1;
            if (h[2].won)      team = h[2].team;
            else if (h[0].won) team = h[0].team;
            else               tie  = 1'b1;
        end
        return {dec, tie, team};
    endfunction

    assign idle_like   = (state == ST_IDLE) || (state == ST_DONE);
    assign begin_hand  = start && idle_like;
    assign card_ready  = (state == ST_COLLECT);
    assign transfer    = card_valid && card_ready;
    assign cmp_clear   = begin_hand || (state == ST_RESOLVE);
    assign next_player = (cur_player == LAST_PLAYER) ? '0 : cur_player + PW'(1);

    assign cur_result.won  = ~tie_flag;
    assign cur_result.team = ~tie_flag & best_player[0];

    assign vaza_done = (state == ST_RESOLVE);
    assign vaza_tie  = vaza_done & tie_flag;
    assign vaza_team = vaza_done & cur_result.team;
    assign hand_done = (state == ST_DONE);

    truco_vaza_cmp #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .RANK_W      (RANK_W)
    ) u_cmp (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (cmp_clear),
        .load        (transfer),
        .first       (card_cnt == '0),
        .card_rank   (card_rank),
        .card_player (cur_player),
        .best_rank   (best_rank),
        .best_player (best_player),
        .tie_flag    (tie_flag)
    );

    // History including the vaza being resolved, fed to the hand rules.
    always_comb begin
        hist_next           = hist;
        hist_next[vaza_idx] = cur_result;
        decision            = decide(hist_next, vaza_idx + 2'd1);
    end

    // Main hand sequencing: start, card collection, vaza resolution, hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            vaza_idx   <= '0;
            cur_player <= '0;
            leader     <= '0;
            card_cnt   <= '0;
            hist       <= '0;
            hand_tie   <= 1'b0;
            hand_team  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_COLLECT;
                        vaza_idx   <= '0;
                        cur_player <= first_player;
                        leader     <= first_player;
                        card_cnt   <= '0;
                        hist       <= '0;
                        hand_tie   <= 1'b0;
                        hand_team  <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (card_valid) begin
                        cur_player <= next_player;
                        if (card_cnt == LAST_CARD) begin
                            card_cnt <= '0;
                            state    <= ST_RESOLVE;
                        end else begin
                            card_cnt <= card_cnt + CW'(1);
                        end
                    end
                end
                ST_RESOLVE: begin
                    hist <= hist_next;
                    if (decision[2]) begin
                        state     <= ST_DONE;
                        hand_tie  <= decision[1];
                        hand_team <= decision[0];
                    end else begin
                        state    <= ST_COLLECT;
                        vaza_idx <= vaza_idx + 2'd1;
                        if (tie_flag) begin
                            cur_player <= leader;
                        end else begin
                            cur_player <= best_player;
                            leader     <= best_player;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^best_rank;

endmodule
